// File: rtl/memory_arbiter_pkg.sv
// Shared bus types for the fetch / load-store memory arbiter.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package memory_arbiter_pkg;

  typedef logic [31:0] word_t;
  typedef logic [3:0]  wstrobe_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2
  } arb_state_t;

  typedef enum logic {
    REQ_I = 1'b0,
    REQ_D = 1'b1
  } requester_t;

  typedef struct packed {
    word_t    address;
    wstrobe_t wstrobe;
    word_t    wdata;
  } bus_req_t;

endpackage

// File: rtl/memory_arbiter_watchdog.sv
// Bus watchdog: counts stalled cycles of an active transaction and flags expiry.
// Latency: expire is combinational in the last allowed cycle; timeout_error one cycle later.
// Backpressure: none; done (bus completion) suppresses expiry in the same cycle.
module memory_arbiter_watchdog #(
  parameter int TIMEOUT_CYCLES = 0,
  parameter int TIMEOUT_WIDTH  = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic active,
  input  logic done,
  output logic expire,
  output logic timeout_error
);

  localparam bit ENABLED = (TIMEOUT_CYCLES > 0);
  localparam logic [TIMEOUT_WIDTH-1:0] LIMIT =
    ENABLED ? TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1) : '0;

  logic [TIMEOUT_WIDTH-1:0] count;

  always_ff @(posedge clk) begin
    if (reset || !ENABLED || start) begin
      count <= '0;
    end else if (active && !done) begin
      count <= count + TIMEOUT_WIDTH'(1);
    end
  end

  assign expire = ENABLED && active && !done && (count == LIMIT);

  always_ff @(posedge clk) begin
    if (reset) begin
      timeout_error <= 1'b0;
    end else begin
      timeout_error <= expire;
    end
  end

endmodule

// File: rtl/memory_arbiter.sv
// Round-robin arbiter sharing the core memory bus between fetch and load/store.
// Latency: grant one cycle after request; one idle bubble after every completion.
// Backpressure: requester holds valid until its ready; the grant is held until m_ready or watchdog expiry.
module memory_arbiter
  import memory_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 0,
  parameter int TIMEOUT_WIDTH  = 8
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     i_valid,
  input  word_t    i_address,
  output logic     i_ready,
  output word_t    i_rdata,
  input  logic     d_valid,
  input  word_t    d_address,
  input  wstrobe_t d_wstrobe,
  input  word_t    d_wdata,
  output logic     d_ready,
  output word_t    d_rdata,
  output logic     m_valid,
  output word_t    m_address,
  output wstrobe_t m_wstrobe,
  output word_t    m_wdata,
  input  logic     m_ready,
  input  word_t    m_rdata,
  output logic     timeout_error
);

  arb_state_t state, next_state;
  requester_t last_grant, next_last_grant;
  bus_req_t   req;
  logic       granted_i, granted_d, req_valid, expire, complete;

  assign granted_i = (state == GRANT_I);
  assign granted_d = (state == GRANT_D);
  assign req_valid = (granted_i && i_valid) || (granted_d && d_valid);
  assign complete  = req_valid && (m_ready || expire);

  memory_arbiter_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .TIMEOUT_WIDTH (TIMEOUT_WIDTH)
  ) u_watchdog (
    .clk          (clk),
    .reset        (reset),
    .start        (state == IDLE),
    .active       (req_valid),
    .done         (m_ready),
    .expire       (expire),
    .timeout_error(timeout_error)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= REQ_I;
    end else begin
      state      <= next_state;
      last_grant <= next_last_grant;
    end
  end

  // A requester dropping valid while granted releases the bus without updating fairness.
  always_comb begin
    next_state      = state;
    next_last_grant = last_grant;
    case (state)
      IDLE: begin
        if (i_valid && d_valid) begin
          next_state = (last_grant == REQ_I) ? GRANT_D : GRANT_I;
        end else if (d_valid) begin
          next_state = GRANT_D;
        end else if (i_valid) begin
          next_state = GRANT_I;
        end
      end
      GRANT_I: begin
        if (!i_valid) begin
          next_state = IDLE;
        end else if (complete) begin
          next_state      = IDLE;
          next_last_grant = REQ_I;
        end
      end
      GRANT_D: begin
        if (!d_valid) begin
          next_state = IDLE;
        end else if (complete) begin
          next_state      = IDLE;
          next_last_grant = REQ_D;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    req = '0;
    if (granted_i) begin
      req.address = i_address;
    end else if (granted_d) begin
      req.address = d_address;
      req.wstrobe = d_wstrobe;
      req.wdata   = d_wdata;
    end
  end

  assign m_valid   = req_valid && !reset;
  assign m_address = req.address;
  assign m_wstrobe = req.wstrobe;
  assign m_wdata   = req.wdata;
  assign i_ready   = granted_i && complete && !reset;
  assign d_ready   = granted_d && complete && !reset;
  assign i_rdata   = expire ? '0 : m_rdata;
  assign d_rdata   = expire ? '0 : m_rdata;

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter with an abstract ownership model checked every cycle.
module tb_memory_arbiter;

  localparam int TO = 4;

  logic        clk;
  logic        reset;
  logic        i_valid, d_valid, m_ready;
  logic [31:0] i_address, d_address, d_wdata, m_rdata;
  logic [3:0]  d_wstrobe;
  logic        i_ready, d_ready, m_valid, timeout_error;
  logic [31:0] i_rdata, d_rdata, m_address, m_wdata;
  logic [3:0]  m_wstrobe;

  memory_arbiter #(.TIMEOUT_CYCLES(TO), .TIMEOUT_WIDTH(8)) dut (
    .clk(clk), .reset(reset),
    .i_valid(i_valid), .i_address(i_address), .i_ready(i_ready), .i_rdata(i_rdata),
    .d_valid(d_valid), .d_address(d_address), .d_wstrobe(d_wstrobe), .d_wdata(d_wdata),
    .d_ready(d_ready), .d_rdata(d_rdata),
    .m_valid(m_valid), .m_address(m_address), .m_wstrobe(m_wstrobe), .m_wdata(m_wdata),
    .m_ready(m_ready), .m_rdata(m_rdata), .timeout_error(timeout_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model: who owns the bus (0 none, 1 fetch, 2 load/store), how long it has waited,
  // who finished last, and whether an error pulse is due.
  int owner     = 0;
  int waited    = 0;
  int last_done = 1;
  bit err_due   = 1'b0;
  bit started   = 1'b0;
  bit on_bus, aborts, finishes;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic sample();
    @(negedge clk);
    on_bus   = 1'b0;
    aborts   = 1'b0;
    finishes = 1'b0;
    if (started) begin
      on_bus   = !reset && ((owner == 1 && i_valid) || (owner == 2 && d_valid));
      aborts   = on_bus && !m_ready && (waited == TO - 1);
      finishes = on_bus && (m_ready || aborts);
      chk("m_valid", 32'(m_valid), 32'(on_bus));
      chk("i_ready", 32'(i_ready), 32'(owner == 1 && finishes));
      chk("d_ready", 32'(d_ready), 32'(owner == 2 && finishes));
      chk("timeout_error", 32'(timeout_error), 32'(err_due));
      if (on_bus) begin
        chk("m_address", m_address, (owner == 1) ? i_address : d_address);
        chk("m_wstrobe", 32'(m_wstrobe), (owner == 1) ? 32'd0 : 32'(d_wstrobe));
        chk("m_wdata", m_wdata, (owner == 1) ? 32'd0 : d_wdata);
      end
      if (owner == 1 && finishes) chk("i_rdata", i_rdata, aborts ? 32'd0 : m_rdata);
      if (owner == 2 && finishes) chk("d_rdata", d_rdata, aborts ? 32'd0 : m_rdata);
    end
  endtask

  task automatic advance();
    if (reset) begin
      owner = 0; waited = 0; last_done = 1; err_due = 1'b0;
    end else begin
      err_due = aborts;
      if (owner == 0) begin
        waited = 0;
        if (i_valid && d_valid) owner = (last_done == 1) ? 2 : 1;
        else if (d_valid)       owner = 2;
        else if (i_valid)       owner = 1;
      end else if (!on_bus) begin
        owner = 0;
      end else if (finishes) begin
        last_done = owner;
        owner = 0;
      end else begin
        waited++;
      end
    end
    @(posedge clk);
    #1;
    started = 1'b1;
  endtask

  task automatic step();
    sample();
    advance();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    i_valid = 1'b0; d_valid = 1'b0; m_ready = 1'b0;
    i_address = 32'h0; d_address = 32'h0; d_wstrobe = 4'h0; d_wdata = 32'h0;
    m_rdata = 32'hDEADBEEF;
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    // Single fetch with two wait cycles.
    do_reset();
    sample();
    chk("s1_rst_mvalid", 32'(m_valid), 32'd0);
    chk("s1_rst_terr", 32'(timeout_error), 32'd0);
    advance();
    i_valid = 1'b1; i_address = 32'h0000_0100;
    sample(); chk("s1_c0_mvalid", 32'(m_valid), 32'd0); advance();
    sample(); chk("s1_c1_mvalid", 32'(m_valid), 32'd1);
    chk("s1_c1_wstrb", 32'(m_wstrobe), 32'd0); advance();
    step();
    m_ready = 1'b1; m_rdata = 32'h0000_0013;
    sample(); chk("s1_iready", 32'(i_ready), 32'd1);
    chk("s1_irdata", i_rdata, 32'h13); advance();
    i_valid = 1'b0; m_ready = 1'b0;
    sample(); chk("s1_idle", 32'(m_valid), 32'd0); advance();

    // Both continuously valid: D, I, D, I on cycles 1, 3, 5, 7.
    do_reset();
    i_valid = 1'b1; i_address = 32'h0000_0200;
    d_valid = 1'b1; d_address = 32'h0000_0300;
    m_ready = 1'b1; m_rdata = 32'h5555_AAAA;
    for (int c = 0; c < 9; c++) begin
      sample();
      chk("s2_dready", 32'(d_ready), 32'(c == 1 || c == 5));
      chk("s2_iready", 32'(i_ready), 32'(c == 3 || c == 7));
      advance();
    end

    // Store from D while I waits.
    do_reset();
    i_valid = 1'b1; i_address = 32'h0000_0400;
    d_valid = 1'b1; d_address = 32'h0000_2002;
    d_wstrobe = 4'b1100; d_wdata = 32'hAABB_CCDD;
    step();
    sample(); chk("s3_wstrb", 32'(m_wstrobe), 32'hC);
    chk("s3_wdata", m_wdata, 32'hAABB_CCDD);
    chk("s3_addr", m_address, 32'h0000_2002); advance();
    m_ready = 1'b1;
    sample(); chk("s3_dready", 32'(d_ready), 32'd1); advance();
    d_valid = 1'b0; m_ready = 1'b0;
    sample(); chk("s3_bubble", 32'(m_valid), 32'd0); advance();
    m_ready = 1'b1; m_rdata = 32'h0BAD_F00D;
    sample(); chk("s3_i_addr", m_address, 32'h0000_0400);
    chk("s3_iready", 32'(i_ready), 32'd1); advance();
    i_valid = 1'b0; m_ready = 1'b0;
    step();

    // Watchdog abort of D, fetch pending.
    do_reset();
    i_valid = 1'b1; i_address = 32'h0000_0500;
    d_valid = 1'b1; d_address = 32'h0000_0600; d_wstrobe = 4'b0000;
    m_rdata = 32'hCAFE_BABE;
    for (int c = 0; c < 4; c++) step();
    sample(); chk("s4_dready", 32'(d_ready), 32'd1);
    chk("s4_drdata", d_rdata, 32'd0);
    chk("s4_terr_early", 32'(timeout_error), 32'd0); advance();
    d_valid = 1'b0;
    sample(); chk("s4_terr", 32'(timeout_error), 32'd1);
    chk("s4_idle", 32'(m_valid), 32'd0); advance();
    m_ready = 1'b1;
    sample(); chk("s4_terr_once", 32'(timeout_error), 32'd0);
    chk("s4_i_addr", m_address, 32'h0000_0500); advance();
    i_valid = 1'b0; m_ready = 1'b0;
    step();

    // m_ready on the last allowed cycle wins over the watchdog.
    do_reset();
    d_valid = 1'b1; d_address = 32'h0000_0700; d_wstrobe = 4'b0001; d_wdata = 32'h0000_0011;
    for (int c = 0; c < 4; c++) step();
    m_ready = 1'b1; m_rdata = 32'h1234_5678;
    sample(); chk("s5_dready", 32'(d_ready), 32'd1);
    chk("s5_drdata", d_rdata, 32'h1234_5678); advance();
    d_valid = 1'b0; m_ready = 1'b0;
    sample(); chk("s5_no_terr", 32'(timeout_error), 32'd0); advance();

    // Reset while fetch is waiting; D wins the first tie afterwards.
    do_reset();
    i_valid = 1'b1; i_address = 32'h0000_0800;
    step();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    d_valid = 1'b1; d_address = 32'h0000_0900; d_wstrobe = 4'b0000;
    sample(); chk("s6_after_rst", 32'(m_valid), 32'd0);
    chk("s6_no_iready", 32'(i_ready), 32'd0); advance();
    sample(); chk("s6_d_first", m_address, 32'h0000_0900); advance();
    i_valid = 1'b0; d_valid = 1'b0;
    step();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/memory_arbiter.md
Name: memory_arbiter

Overview:
- Shares the single core memory bus between the instruction-fetch requester and the load/store requester.
- The load/store requester's strobes and data are already formatted upstream.
- Registered round-robin grant, held for the whole transaction; optional watchdog completes hung transactions with an error pulse.
- Sits between fetch/load-store logic and the memory/interconnect port of the core.

Parameters:
- TIMEOUT_CYCLES, 0, max cycles a granted transaction may wait for m_ready; 0 disables the watchdog.
- TIMEOUT_WIDTH, 8, width of the watchdog counter; TIMEOUT_CYCLES must be < 2**TIMEOUT_WIDTH.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- i_valid  in  1  fetch request; held with i_address until i_ready.
- i_address  in  32 (word_t)  fetch address.
- i_ready  out  1  fetch completion strobe; i_rdata valid this cycle.
- i_rdata  out  32 (word_t)  fetched word.
- d_valid  in  1  load/store request; held with address/strobe/data until d_ready.
- d_address  in  32 (word_t)  load/store address.
- d_wstrobe  in  4 (wstrobe_t)  byte strobes; 0 means load.
- d_wdata  in  32 (word_t)  store data, already lane-replicated.
- d_ready  out  1  load/store completion strobe.
- d_rdata  out  32 (word_t)  raw load word (unaligned; alignment/extension is done downstream).
- m_valid  out  1  shared-bus request.
- m_address  out  32 (word_t)  shared-bus address.
- m_wstrobe  out  4 (wstrobe_t)  shared-bus strobes.
- m_wdata  out  32 (word_t)  shared-bus write data.
- m_ready  in  1  shared-bus completion.
- m_rdata  in  32 (word_t)  shared-bus read data.
- timeout_error  out  1  one-cycle pulse when the watchdog aborts a transaction.

Behaviour:
- State machine arb_state_t: IDLE, GRANT_I, GRANT_D. Registers: state, last_grant (1 bit: 0=I, 1=D), wait counter, timeout_error.
- Reset: state=IDLE, last_grant=I (so D wins the first tie), counter=0, timeout_error=0.
- Reset outputs: m_valid=0, i_ready=0, d_ready=0. m_address, m_wstrobe, m_wdata, i_rdata, d_rdata are don't-care but never X-driving control.
- Reset mid-transaction: the next cycle is IDLE with m_valid=0. The bus transaction is abandoned and no ready is issued.
- IDLE, next state:
  - only i_valid -> GRANT_I.
  - only d_valid -> GRANT_D.
  - both -> the requester not equal to last_grant.
  - neither -> stay.
  - m_valid=0 in IDLE.
- Grant latency: request sampled in IDLE at cycle t; m_valid=1 from cycle t+1.
- GRANT_x (combinational outputs):
  - m_valid = x_valid.
  - m_address = x_address.
  - m_wstrobe = d_wstrobe for D, 4'b0000 for I.
  - m_wdata = d_wdata for D, 0 for I.
- Completion: x_ready = m_ready & m_valid while in GRANT_x; the other ready is 0. i_rdata and d_rdata are both driven from m_rdata every cycle.
- On completion: last_grant <= x; state <= IDLE. A one-cycle bubble is mandatory: one transaction per two cycles at best.
- Requester drops valid while granted (protocol violation): m_valid falls the same cycle; state <= IDLE next cycle; last_grant unchanged.
- Watchdog (TIMEOUT_CYCLES>0):
  - Counter clears on entry to GRANT_x and increments each GRANT cycle without m_ready.
  - When counter == TIMEOUT_CYCLES-1 and m_ready=0, force x_ready=1 with x_rdata=0 that cycle.
  - Next cycle: timeout_error=1 for one cycle; last_grant <= x; state <= IDLE.
  - m_ready arriving on the timeout cycle takes precedence: normal completion, no error.
- TIMEOUT_CYCLES=0: counter held at 0; timeout_error never asserts.
- Simultaneous events: a new request arriving in the completion cycle is not granted until the following IDLE cycle. Grant never changes mid-transaction, regardless of the other requester.
- Fairness: with both requesters continuously valid, grants strictly alternate D, I, D, I...

Decomposition:
- Types_pkg already holds word_t and wstrobe_t.
- Add arb_state_t (enum IDLE/GRANT_I/GRANT_D) to a shared Bus_pkg, alongside a requester_t enum (REQ_I, REQ_D) for last_grant.
- One natural sub-module: bus_watchdog (counter, compare, error pulse; inputs start/active/done, output expire), reusable on other bus masters.

Test Plan:
- Reset then i_valid=1 at 0x00000100 alone, m_ready held 0 for 2 cycles then 1 with m_rdata=0x00000013 -> m_valid from cycle 1; i_ready=1 and i_rdata=0x13 in the ready cycle; m_wstrobe=0 throughout.
- Both valid from reset, m_ready=1 always -> grants D,I,D,I on cycles 1,3,5,7; d_ready/i_ready alternate; i_ready never coincides with d_ready.
- D store 0xAABBCCDD, d_wstrobe=4'b1100, address 0x2002 while I waits -> m_wstrobe=4'b1100, m_wdata=0xAABBCCDD; I is granted only after d_ready plus one IDLE cycle.
- TIMEOUT_CYCLES=4, D granted, m_ready never asserted -> d_ready=1 with d_rdata=0 in the 4th granted cycle; timeout_error=1 in the next cycle only; pending I is granted after.
- TIMEOUT_CYCLES=4, m_ready=1 exactly in the 4th granted cycle -> normal completion with m_rdata; timeout_error stays 0.
- reset asserted while GRANT_I waits on m_ready -> next cycle m_valid=0, i_ready never pulses; after release, with both valid, D is granted first.
